// File: rtl/udma_tx_packer.sv
// udma_tx_packer: packs a 32-bit valid/ready stream into 64-bit TX buffer writes with pad and flush
module udma_tx_packer #(
  parameter logic [31:0] PAD_WORD = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             uDMA_wrclk,
  input  logic             uDMA_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  input  logic             flush_req,
  output logic             flush_ack,
  input  logic             uDMA_almost_full,
  output logic             uDMA_wren,
  output logic [63:0]      uDMA_data,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] pad_cnt,
  output logic             busy
);
  logic [31:0] half_reg;
  logic        half_vld;
  logic [63:0] pend_reg;
  logic        pend_vld;
  logic        accept, drain, flush_go, load, hold_half;
  logic [63:0] load_data;
  assign in_ready = !pend_vld || !uDMA_almost_full;
  assign accept   = in_valid && in_ready;
  assign drain    = pend_vld && !uDMA_almost_full;
  assign busy     = half_vld || pend_vld || uDMA_wren;
  // flush waits for an idle input slot and skips the ack cycle so one held request is serviced once
  always_comb begin
    flush_go  = flush_req && !accept && in_ready && !flush_ack;
    hold_half = accept && !half_vld && !in_last;
    load      = (accept && (half_vld || in_last)) || (flush_go && half_vld);
    load_data = !accept ? {PAD_WORD, half_reg} : half_vld ? {in_data, half_reg} : {PAD_WORD, in_data};
  end
  // packing, pending-word drain and event counters
  always_ff @(posedge uDMA_wrclk) begin
    if (uDMA_rst) begin
      half_reg  <= '0;
      half_vld  <= 1'b0;
      pend_reg  <= '0;
      pend_vld  <= 1'b0;
      uDMA_wren <= 1'b0;
      uDMA_data <= '0;
      flush_ack <= 1'b0;
      word_cnt  <= '0;
      frame_cnt <= '0;
      pad_cnt   <= '0;
    end else begin
      uDMA_wren <= drain;
      flush_ack <= flush_go;
      pend_vld  <= load || (pend_vld && !drain);
      half_vld  <= hold_half ? 1'b1 : load ? 1'b0 : half_vld;
      if (hold_half) half_reg <= in_data;
      if (load) pend_reg <= load_data;
      if (drain) begin
        uDMA_data <= pend_reg;
        word_cnt  <= word_cnt + CNT_W'(1);
      end
      if (accept && in_last) frame_cnt <= frame_cnt + CNT_W'(1);
      if (load && !(accept && half_vld)) pad_cnt <= pad_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_udma_tx_packer.sv
// tb_udma_tx_packer: directed self-checking bench for udma_tx_packer
module tb_udma_tx_packer;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last, flush_req, flush_ack, af, wren, busy;
  logic [31:0] in_data;
  logic [63:0] wdata;
  logic [31:0] word_cnt, frame_cnt, pad_cnt;
  logic [63:0] wq[$];
  int total = 0;
  int bad = 0;

  udma_tx_packer dut (
    .uDMA_wrclk(clk), .uDMA_rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .flush_req(flush_req), .flush_ack(flush_ack),
    .uDMA_almost_full(af), .uDMA_wren(wren), .uDMA_data(wdata), .word_cnt(word_cnt),
    .frame_cnt(frame_cnt), .pad_cnt(pad_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && wren) wq.push_back(wdata);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    in_valid = 0; in_last = 0; in_data = 0; flush_req = 0; af = 0;
    rst = 1;
    tick; tick;
    rst = 0;
    wq.delete();
  endtask

  task automatic test_reset;
    do_reset;
    total++; if (wren !== 1'b0) begin bad++; $display("FAIL reset_wren got=%b want=0", wren); end
    total++; if (wdata !== 64'h0) begin bad++; $display("FAIL reset_data got=%h want=0", wdata); end
    total++; if ({word_cnt, frame_cnt, pad_cnt} !== 96'h0) begin bad++; $display("FAIL reset_cnt got=%h/%h/%h want=0", word_cnt, frame_cnt, pad_cnt); end
    total++; if ({in_ready, busy, flush_ack} !== 3'b100) begin bad++; $display("FAIL reset_ctrl got=%b want=100", {in_ready, busy, flush_ack}); end
  endtask

  task automatic test_pair;
    do_reset;
    in_valid = 1; in_data = 32'h1111_1111; tick;
    in_data = 32'h2222_2222; tick;
    in_valid = 0;
    total++; if ({wren, busy} !== 2'b01) begin bad++; $display("FAIL pair_pending got=%b want=01", {wren, busy}); end
    tick;
    total++; if (wren !== 1'b1 || wdata !== 64'h2222_2222_1111_1111) begin bad++; $display("FAIL pair_write got=%b/%h want=1/2222222211111111", wren, wdata); end
    total++; if (word_cnt !== 32'd1) begin bad++; $display("FAIL pair_word_cnt got=%0d want=1", word_cnt); end
    tick;
    total++; if (wren !== 1'b0 || wq.size() != 1) begin bad++; $display("FAIL pair_single got=%b/%0d want=0/1", wren, wq.size()); end
  endtask

  task automatic test_odd_frame;
    do_reset;
    in_valid = 1; in_data = 32'hAAAA_0001; tick;
    in_data = 32'hBBBB_0002; tick;
    in_data = 32'hCCCC_0003; in_last = 1; tick;
    in_valid = 0; in_last = 0;
    tick; tick; tick;
    total++; if (wq.size() != 2) begin bad++; $display("FAIL odd_count got=%0d want=2", wq.size()); end
    else begin
      total++; if (wq[0] !== 64'hBBBB_0002_AAAA_0001) begin bad++; $display("FAIL odd_w0 got=%h want=bbbb0002aaaa0001", wq[0]); end
      total++; if (wq[1] !== 64'h0000_0000_CCCC_0003) begin bad++; $display("FAIL odd_w1 got=%h want=00000000cccc0003", wq[1]); end
    end
    total++; if ({word_cnt, frame_cnt, pad_cnt} !== {32'd2, 32'd1, 32'd1}) begin bad++; $display("FAIL odd_cnt got=%0d/%0d/%0d want=2/1/1", word_cnt, frame_cnt, pad_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL odd_idle got=%b want=0", busy); end
  endtask

  task automatic test_backpressure;
    int i = 0;
    int cyc = 0;
    int viol = 0;
    int rdy_hi = 0;
    logic af_prev;
    logic acc;
    do_reset;
    while (i < 6 && cyc < 60) begin
      af = (cyc >= 2 && cyc < 12);
      in_valid = 1; in_data = 32'h5000_0000 + 32'(i); in_last = (i == 5);
      #1;
      if (af && in_ready) rdy_hi++;
      acc = in_ready; af_prev = af;
      tick;
      if (af_prev && wren) viol++;
      if (acc) i++;
      cyc++;
    end
    in_valid = 0; in_last = 0; af = 0;
    total++; if (i != 6) begin bad++; $display("FAIL bp_timeout got=%0d want=6 accepted", i); end
    tick; tick; tick; tick;
    total++; if (viol != 0) begin bad++; $display("FAIL bp_wren_while_full got=%0d want=0", viol); end
    total++; if (rdy_hi != 0) begin bad++; $display("FAIL bp_ready_while_full got=%0d want=0", rdy_hi); end
    total++; if (wq.size() != 3) begin bad++; $display("FAIL bp_count got=%0d want=3", wq.size()); end
    else for (int k = 0; k < 3; k++) begin
      total++; if (wq[k] !== {32'h5000_0000 + 32'(2*k+1), 32'h5000_0000 + 32'(2*k)}) begin bad++; $display("FAIL bp_word%0d got=%h", k, wq[k]); end
    end
    total++; if ({word_cnt, frame_cnt, pad_cnt} !== {32'd3, 32'd1, 32'd0}) begin bad++; $display("FAIL bp_cnt got=%0d/%0d/%0d want=3/1/0", word_cnt, frame_cnt, pad_cnt); end
  endtask

  task automatic test_flush;
    int n;
    do_reset;
    in_valid = 1; in_data = 32'hDEAD_BEEF; tick;
    in_valid = 0; flush_req = 1;
    n = 0;
    while (!flush_ack && n < 10) begin tick; n++; end
    total++; if (flush_ack !== 1'b1) begin bad++; $display("FAIL flush_ack_timeout got=%b want=1", flush_ack); end
    flush_req = 0;
    tick;
    total++; if (flush_ack !== 1'b0) begin bad++; $display("FAIL flush_pulse got=%b want=0", flush_ack); end
    tick;
    total++; if (wq.size() != 1 || wq[0] !== 64'h0000_0000_DEAD_BEEF) begin bad++; $display("FAIL flush_write got=%0d words want=1 of 00000000deadbeef", wq.size()); end
    total++; if (pad_cnt !== 32'd1) begin bad++; $display("FAIL flush_pad got=%0d want=1", pad_cnt); end
    flush_req = 1;
    n = 0;
    while (!flush_ack && n < 10) begin tick; n++; end
    total++; if (flush_ack !== 1'b1) begin bad++; $display("FAIL flush_empty_ack got=%b want=1", flush_ack); end
    flush_req = 0;
    tick; tick; tick;
    total++; if (wq.size() != 1 || word_cnt !== 32'd1 || pad_cnt !== 32'd1) begin bad++; $display("FAIL flush_empty_nowrite got=%0d/%0d/%0d want=1/1/1", wq.size(), word_cnt, pad_cnt); end
  endtask

  task automatic test_flush_collide;
    do_reset;
    in_valid = 1; in_data = 32'h0000_00A1; tick;
    in_data = 32'h0000_00B2; flush_req = 1; tick;
    in_valid = 0;
    total++; if (flush_ack !== 1'b0) begin bad++; $display("FAIL collide_early_ack got=%b want=0", flush_ack); end
    tick;
    total++; if ({flush_ack, wren} !== 2'b11 || wdata !== 64'h0000_00B2_0000_00A1) begin bad++; $display("FAIL collide_ack_write got=%b/%h want=11/000000b2000000a1", {flush_ack, wren}, wdata); end
    flush_req = 0;
    tick; tick;
    total++; if (wq.size() != 1 || pad_cnt !== 32'd0 || word_cnt !== 32'd1) begin bad++; $display("FAIL collide_extra got=%0d/%0d/%0d want=1/0/1", wq.size(), pad_cnt, word_cnt); end
  endtask

  task automatic test_reset_stalled;
    do_reset;
    af = 1;
    in_valid = 1; in_data = 32'h7777_0001; in_last = 0; tick;
    in_data = 32'h7777_0002; in_last = 1; tick;
    in_valid = 0; in_last = 0;
    tick; tick;
    total++; if ({busy, wren, in_ready} !== 3'b100) begin bad++; $display("FAIL stall_state got=%b want=100", {busy, wren, in_ready}); end
    rst = 1; tick;
    rst = 0;
    total++; if ({in_ready, busy} !== 2'b10) begin bad++; $display("FAIL stall_reset_ready got=%b want=10", {in_ready, busy}); end
    total++; if ({word_cnt, frame_cnt, pad_cnt} !== 96'h0) begin bad++; $display("FAIL stall_reset_cnt got=%h/%h/%h want=0", word_cnt, frame_cnt, pad_cnt); end
    af = 0;
    tick; tick; tick;
    total++; if (wq.size() != 0 || wren !== 1'b0) begin bad++; $display("FAIL stall_discard got=%0d/%b want=0/0", wq.size(), wren); end
  endtask

  initial begin
    test_reset;
    test_pair;
    test_odd_frame;
    test_backpressure;
    test_flush;
    test_flush_collide;
    test_reset_stalled;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
